// File: rtl/systolic_row_feeder_pkg.sv
// systolic_row_feeder_pkg: feeder state encoding and default array geometry shared with the FIFOs and PE array
package systolic_row_feeder_pkg;
    localparam int DEF_ROWS = 32;
    localparam int DEF_BWIDTH = 8;
    localparam int DEF_KW = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/systolic_row_feeder_lane.sv
// systolic_row_feeder_lane: due window and west-edge operand register for one array row
module systolic_row_feeder_lane
    import systolic_row_feeder_pkg::*;
#(
    parameter int ROW = 0,
    parameter int BWIDTH = DEF_BWIDTH,
    parameter int KW = DEF_KW
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              run,
    input  logic [KW:0]       step,
    input  logic [KW-1:0]     klen_q,
    input  logic              go,
    input  logic [BWIDTH-1:0] din,
    output logic              due,
    output logic              pop,
    output logic [BWIDTH-1:0] a_out,
    output logic              a_valid
);
    logic signed [KW+1:0] rel;
    // one extra bit so step-ROW can go negative before this row's turn
    assign rel = $signed({1'b0, step}) - $signed((KW+2)'(ROW));
    assign due = run & ~rel[KW+1] & (rel < $signed({2'b00, klen_q}));
    assign pop = go & due;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            a_out <= '0;
            a_valid <= 1'b0;
        end else begin
            a_out <= pop ? din : '0;
            a_valid <= pop;
        end
    end
endmodule

// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder: drains per-row FIFOs into the PE array west edge with a diagonal skew
module systolic_row_feeder
    import systolic_row_feeder_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int BWIDTH = DEF_BWIDTH,
    parameter int KW = DEF_KW
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   START,
    input  logic [KW-1:0]          K_LEN,
    input  logic [ROWS-1:0]        FIFO_EMPTY,
    input  logic [ROWS*BWIDTH-1:0] FIFO_DOUT,
    output logic [ROWS-1:0]        FIFO_POPE,
    output logic [ROWS*BWIDTH-1:0] A_OUT,
    output logic [ROWS-1:0]        A_VALID,
    output logic                   BUSY,
    output logic                   DONE
);
    state_t state, state_nx;
    logic [KW:0] step;
    logic [KW-1:0] klen_q;
    logic [ROWS-1:0] due;
    logic run, go, last;
    assign run = state == ST_RUN;
    // any due row without data freezes every row so the skew survives the stall
    assign go = &(~FIFO_EMPTY | ~due);
    assign last = step == {1'b0, klen_q} + (KW+1)'(ROWS - 2);
    assign BUSY = state != ST_IDLE;
    assign DONE = state == ST_DONE;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= ST_IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (START) state_nx = (K_LEN != '0) ? ST_RUN : ST_DONE;
            ST_RUN: if (go && last) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            step <= '0;
            klen_q <= '0;
        end else if (state == ST_IDLE && START && K_LEN != '0) begin
            step <= '0;
            klen_q <= K_LEN;
        end else if (run && go) begin
            step <= step + (KW+1)'(1);
        end
    end
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        systolic_row_feeder_lane #(.ROW(i), .BWIDTH(BWIDTH), .KW(KW)) u_lane (
            .CLK(CLK),
            .RSTn(RSTn),
            .run(run),
            .step(step),
            .klen_q(klen_q),
            .go(go),
            .din(FIFO_DOUT[i*BWIDTH +: BWIDTH]),
            .due(due[i]),
            .pop(FIFO_POPE[i]),
            .a_out(A_OUT[i*BWIDTH +: BWIDTH]),
            .a_valid(A_VALID[i])
        );
    end
endmodule

// File: tb/tb_systolic_row_feeder.sv
// tb_systolic_row_feeder: scoreboard bench with a FIFO model, per-lane expected queues and a negedge monitor
module tb_systolic_row_feeder;
    localparam int ROWS = 4;
    localparam int BW = 8;
    localparam int KW = 8;
    typedef struct {int c; logic [7:0] d;} av_t;
    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic START = 1'b0;
    logic [KW-1:0] K_LEN = '0;
    logic [ROWS-1:0] FIFO_EMPTY = '1;
    logic [ROWS*BW-1:0] FIFO_DOUT = '0;
    logic [ROWS-1:0] FIFO_POPE;
    logic [ROWS*BW-1:0] A_OUT;
    logic [ROWS-1:0] A_VALID;
    logic BUSY, DONE;
    int exp_pop[ROWS][$];
    av_t exp_av[ROWS][$];
    int exp_done[$];
    logic [7:0] fq[ROWS][$];
    int cyc = 0;
    int base = 0;
    int busy_hi = 0;
    int flush_cnt = 0;
    int flush_seen = 0;
    int checks = 0;
    int errors = 0;
    bit stall_en = 1'b0;
    systolic_row_feeder #(.ROWS(ROWS), .BWIDTH(BW), .KW(KW)) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .START(START),
        .K_LEN(K_LEN),
        .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_DOUT(FIFO_DOUT),
        .FIFO_POPE(FIFO_POPE),
        .A_OUT(A_OUT),
        .A_VALID(A_VALID),
        .BUSY(BUSY),
        .DONE(DONE)
    );
    always #5 CLK = ~CLK;
    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - base + 1);
        end
    endtask
    // FIFO model: pops what the DUT strobed at the edge, then presents the new heads
    always @(posedge CLK) begin
        logic [ROWS-1:0] p;
        int rel;
        p = RSTn ? FIFO_POPE : '0;
        cyc++;
        #1;
        rel = cyc - base + 1;
        for (int i = 0; i < ROWS; i++) begin
            if (p[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            FIFO_EMPTY[i] = fq[i].size() == 0 || (stall_en && i == 2 && rel >= 3 && rel <= 5);
            FIFO_DOUT[i*BW +: BW] = fq[i].size() > 0 ? fq[i][0] : 8'hEE;
        end
    end
    always @(negedge CLK) begin
        int rel;
        av_t e;
        rel = cyc - base + 1;
        if (flush_cnt != flush_seen) begin
            flush_seen = flush_cnt;
            for (int i = 0; i < ROWS; i++) begin
                check($sformatf("pops_missing lane%0d", i), exp_pop[i].size(), 0);
                check($sformatf("valids_missing lane%0d", i), exp_av[i].size(), 0);
                exp_pop[i].delete();
                exp_av[i].delete();
            end
            check("done_missing", exp_done.size(), 0);
            exp_done.delete();
        end
        if (!RSTn) begin
            check("reset_outputs_zero", int'(|{FIFO_POPE, A_VALID, A_OUT, BUSY, DONE}), 0);
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (FIFO_POPE[i]) begin
                    if (exp_pop[i].size() == 0) check($sformatf("pop_unexpected lane%0d", i), rel, -1);
                    else check($sformatf("pop_cycle lane%0d", i), rel, exp_pop[i].pop_front());
                end
                if (A_VALID[i]) begin
                    if (exp_av[i].size() == 0) check($sformatf("valid_unexpected lane%0d", i), rel, -1);
                    else begin
                        e = exp_av[i].pop_front();
                        check($sformatf("valid_cycle lane%0d", i), rel, e.c);
                        check($sformatf("a_out lane%0d", i), int'(A_OUT[i*BW +: BW]), int'(e.d));
                    end
                end else begin
                    check($sformatf("a_out_idle lane%0d", i), int'(A_OUT[i*BW +: BW]), 0);
                end
            end
            if (DONE) begin
                if (exp_done.size() == 0) check("done_unexpected", rel, -1);
                else check("done_cycle", rel, exp_done.pop_front());
            end
            check("busy", int'(BUSY), int'(rel >= 1 && rel <= busy_hi));
        end
    end
    // row r holds r*16+j; a stall freezes all lanes for 3 cycles once step reaches 2
    task automatic run_tile(int k, bit stall, int restart, int rst_at);
        int done_c, len, s, pc;
        @(posedge CLK); #2;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < (k > 0 ? k : 2); j++) fq[i].push_back(8'(i*16 + j));
        stall_en = stall;
        @(posedge CLK); #2;
        done_c = k == 0 ? 1 : k + ROWS + 1 + (stall ? 3 : 0);
        busy_hi = rst_at > 0 ? rst_at : done_c;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < k; j++) begin
                s = i + j;
                pc = 1 + s + ((stall && s >= 2) ? 3 : 0);
                if (rst_at == 0 || pc <= rst_at) exp_pop[i].push_back(pc);
                if (rst_at == 0 || pc + 1 <= rst_at) exp_av[i].push_back('{c: pc + 1, d: 8'(i*16 + j)});
            end
        if (rst_at == 0) exp_done.push_back(done_c);
        base = cyc + 1;
        START = 1'b1;
        K_LEN = 8'(k);
        len = rst_at > 0 ? rst_at + 4 : done_c + 3;
        for (int c = 1; c <= len; c++) begin
            @(posedge CLK); #2;
            START = c == restart;
            K_LEN = c == restart ? 8'd2 : 8'(c*37 + 5);
            if (rst_at > 0 && c == rst_at) begin
                #5;
                RSTn = 1'b0;
            end
            if (rst_at > 0 && c == rst_at + 3) RSTn = 1'b1;
        end
        @(posedge CLK); #2;
        flush_cnt++;
        stall_en = 1'b0;
        for (int i = 0; i < ROWS; i++) fq[i].delete();
        @(posedge CLK); #2;
    endtask
    initial begin
        repeat (3) @(posedge CLK);
        #2 RSTn = 1'b1;
        run_tile(3, 1'b0, 0, 0);
        run_tile(3, 1'b1, 0, 0);
        run_tile(0, 1'b0, 0, 0);
        run_tile(3, 1'b0, 4, 0);
        run_tile(3, 1'b0, 0, 4);
        run_tile(3, 1'b0, 0, 0);
        run_tile(1, 1'b0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_row_feeder.md
Name: systolic_row_feeder

Overview:
- Drains ROWS per-row operand FIFOs and drives the west edge of the PE array with diagonally skewed data.
- Row i enters the array i cycles after row 0, which gives the systolic wavefront its shape.
- Sits directly downstream of the row FIFOs (one FIFO per array row) and directly upstream of the PE array.
- Stalls the whole wavefront whenever any row that is due has no data, so the skew is never broken.

Parameters:
- ROWS, 32, number of PE rows and feeder lanes.
- BWIDTH, 8, operand width (INT8).
- KW, 8, width of K_LEN; constraint ROWS <= 2^KW.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request to stream one tile; sampled only in IDLE.
- K_LEN  in  KW  elements per row for this tile; captured on an accepted START.
- FIFO_EMPTY  in  ROWS  bit i high = row-i FIFO holds no data.
- FIFO_DOUT  in  ROWS*BWIDTH  head word of each FIFO, valid combinationally; lane i at bits [i*BWIDTH +: BWIDTH].
- FIFO_POPE  out  ROWS  pop strobe per FIFO; the head advances at the next edge.
- A_OUT  out  ROWS*BWIDTH  registered operands to the PE array west edge.
- A_VALID  out  ROWS  registered per-lane valid.
- BUSY  out  1  high in every state other than IDLE.
- DONE  out  1  one-cycle pulse when the tile is fully issued.

Behaviour:
- Reset (async, RSTn low): state=IDLE, step=0, klen_q=0, FIFO_POPE=0, A_OUT=0, A_VALID=0, BUSY=0, DONE=0. Reset mid-tile abandons the tile; no further pops occur.
- State IDLE
  - START=1 and K_LEN!=0: capture klen_q=K_LEN, step=0, go to RUN.
  - START=1 and K_LEN=0: go straight to DONE; no pops.
- State RUN: step counter is KW+1 bits, range 0..klen_q+ROWS-2.
  - Lane i is due when 0 <= step-i <= klen_q-1 (evaluate with signed or widened arithmetic).
  - go = AND over due lanes of ~FIFO_EMPTY[i].
  - FIFO_POPE[i] = go & due[i] (combinational).
  - Next edge:
    - A_OUT lane i <= FIFO_DOUT lane i if popped, else 0.
    - A_VALID[i] <= popped[i].
    - If go: step++; if step == klen_q+ROWS-2, go to DRAIN.
  - If go=0 (stall): no pops anywhere, A_VALID<=0, A_OUT<=0, step holds.
- State DRAIN: one cycle; the last registered data is presented; no pops. Next edge: A_VALID<=0, A_OUT<=0, go to DONE.
- State DONE: DONE=1 for exactly one cycle, BUSY=1; then IDLE.
- START outside IDLE is ignored. K_LEN changes outside the accepting cycle are ignored.
- Latency: a pop at cycle t gives A_VALID/A_OUT at t+1.
- Ordering: row i always outputs its elements in FIFO order at relative offset i from row 0, provided there are no stalls; stalls shift all lanes equally.
- Total RUN cycles = klen_q+ROWS-1 plus the number of stall cycles.

Decomposition:
- Shared package:
  - State encoding (IDLE, RUN, DRAIN, DONE).
  - Default ROWS/BWIDTH constants, shared with the FIFO and the PE array.
  - Lane-slice helper constant BWIDTH.
- Sub-module feeder_lane:
  - One instance per row.
  - Inputs: step, klen_q, row index constant, stall/go.
  - Produces due[i] and the A_OUT/A_VALID lane registers.
  - Top level keeps the FSM, step counter and the go AND-reduction.

Test Plan (ROWS=4, BWIDTH=8):
- Basic skew:
  - Stimulus: FIFOs preloaded row r = {r*16+0, r*16+1, r*16+2}, K_LEN=3, START accepted at edge 0.
  - Response: FIFO_POPE[0] high cycles 1-3, FIFO_POPE[3] high cycles 4-6. A_VALID[0] high cycles 2-4 with 0x00,0x01,0x02. A_VALID[3] high cycles 5-7 with 0x30,0x31,0x32. DONE pulses at cycle 8. BUSY high cycles 1-8.
- Stall:
  - Stimulus: same as basic skew, but row-2 FIFO empty from cycle 3, refilled at cycle 6.
  - Response: zero pops on every lane during cycles 3-5. Every lane's sequence shifts by 3 cycles with relative skew unchanged. DONE at cycle 11.
- Zero length:
  - Stimulus: K_LEN=0 with START.
  - Response: no FIFO_POPE at any time. DONE one cycle after the accepting edge. A_VALID stays 0.
- START while busy:
  - Stimulus: second START at cycle 4 during the basic-skew tile.
  - Response: ignored; the output trace is identical to the basic-skew case.
- Reset mid-tile:
  - Stimulus: RSTn low asynchronously at cycle 4.5.
  - Response: all outputs 0 immediately and no DONE. A fresh START after release replays correctly from step 0.
- K_LEN=1:
  - Stimulus: K_LEN=1 with START.
  - Response: each lane pops once, on cycles 1,2,3,4 for lanes 0..3. DONE at cycle 6.
